// File: rtl/program_memory_banked.sv
// Loadable shared program store: image streamed in after reset, then read by
// NUM_PORTS fetch ports through address-interleaved banks with per-bank round-robin.
module program_memory_banked #(
  parameter int unsigned NUM_PORTS  = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load_valid,
  input  logic [ADDR_WIDTH-1:0]            load_addr,
  input  logic [DATA_WIDTH-1:0]            load_data,
  input  logic                             load_last,
  output logic                             load_ready,
  output logic                             run,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem       [DEPTH];
  logic [PTR_W-1:0]      ptr       [NUM_BANKS];
  logic [PTR_W-1:0]      ptr_nxt   [NUM_BANKS];
  logic [BANK_BITS-1:0]  port_bank [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_rd   [NUM_PORTS];
  logic                  load_fire;
  logic                  fetch_en;
  logic                  arb_found;
  int unsigned           arb_idx;
  int unsigned           arb_win;
  logic [PTR_W-1:0]      arb_sel;

  assign load_ready = (state == ST_LOAD);
  assign run        = (state == ST_RUN);
  assign load_fire  = load_valid && load_ready && reset;
  // reset term keeps grants low even in the delta before state settles
  assign fetch_en   = run && reset;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (load_fire && load_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = '0;
      if (NUM_BANKS > 1) port_bank[p] = addr[p*ADDR_WIDTH +: BANK_BITS];
    end
  end

  // Each bank picks at most one requester, so each bank performs one array read.
  always_comb begin
    gnt       = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    arb_win   = 0;
    arb_sel   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) port_rd[p] = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      ptr_nxt[b] = ptr[b];
      arb_found  = 1'b0;
      arb_win    = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        arb_idx = 32'(ptr[b]) + i;
        if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
        arb_sel = PTR_W'(arb_idx);
        if (!arb_found && fetch_en && req[arb_sel] &&
            (port_bank[arb_sel] == BANK_BITS'(b))) begin
          arb_found = 1'b1;
          arb_win   = arb_idx;
        end
      end
      if (arb_found) begin
        arb_sel          = PTR_W'(arb_win);
        gnt[arb_sel]     = 1'b1;
        port_rd[arb_sel] = mem[addr[arb_win*ADDR_WIDTH +: ADDR_WIDTH]];
        ptr_nxt[b]       = (arb_win == NUM_PORTS - 1) ? '0 : PTR_W'(arb_win + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_LOAD;
      rvalid <= '0;
      rdata  <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) ptr[b] <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= gnt;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (gnt[p]) rdata[p*DATA_WIDTH +: DATA_WIDTH] <= port_rd[p];
      end
      for (int unsigned b = 0; b < NUM_BANKS; b++) ptr[b] <= ptr_nxt[b];
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[load_addr] <= load_data;
  end

endmodule

// File: doc/program_memory_banked.md
# program_memory_banked

Parametrised successor to the fixed 16-port program ROM. It holds the shared instruction store for the multicore array, with NUM_PORTS core fetch ports. The image is streamed in through a load port after reset rather than hard-coded. Storage is split into NUM_BANKS address-interleaved single-read banks, so fetches contend per bank under round-robin arbitration and read data is registered.

## Interface
- NUM_PORTS, 16, number of core fetch ports (≥1)
- ADDR_WIDTH, 8, address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 8, word width
- NUM_BANKS, 4, interleave factor; power of two, 1 ≤ NUM_BANKS ≤ 2^ADDR_WIDTH; bank = addr[log2(NUM_BANKS)-1:0]

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  load beat present
- load_addr  in  ADDR_WIDTH  load beat address
- load_data  in  DATA_WIDTH  load beat word
- load_last  in  1  final beat of image
- load_ready  out  1  load port accepting (LOAD state)
- run  out  1  image loaded, fetch ports live
- req  in  NUM_PORTS  per-port fetch request
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_PORTS  per-port grant, combinational, same cycle as req
- rvalid  out  NUM_PORTS  per-port read data valid, registered
- rdata  out  NUM_PORTS*DATA_WIDTH  per-port read word, packed like addr

## Operation
- FSM states: LOAD, RUN. Reset enters LOAD.
- LOAD:
  - load_ready=1 and all gnt=0.
  - A beat is accepted when load_valid && load_ready. On that edge, mem[load_addr] <= load_data.
  - An accepted beat with load_last=1 moves the FSM to RUN.
  - Beats may arrive in any address order. Repeated addresses overwrite; the last write wins.
- RUN:
  - load_ready=0. load_* inputs are ignored and cannot write.
  - Remains in RUN until reset.
- Arbitration, independently per bank:
  - Candidates are the ports with req=1 whose address maps to that bank.
  - Exactly one candidate is granted: the first at or after that bank's pointer, scanning upward with wrap at NUM_PORTS.
  - On a grant to port g, the pointer becomes (g+1) mod NUM_PORTS. With no grant, the pointer holds.
  - Pointers reset to 0.
  - Requests for the same address from different ports still conflict; there is no broadcast.
  - Ports on different banks are granted in the same cycle.
- Requester rule: hold req and addr stable until gnt. Dropping req before gnt is legal and simply withdraws the request.
- A granted port may request again in the next cycle, to any address.
- Memory array has no reset. Contents after reset are retained but must be reloaded before use.

## Timing
- Reset values, asserted asynchronously: state=LOAD, load_ready=1, run=0, gnt=0, rvalid=0, rdata=0, all bank pointers 0.
- run is registered and rises on the clock edge that accepts the load_last beat. Grants are possible from the following cycle.
- Read latency is 1:
  - gnt[p]=1 in cycle N gives rvalid[p]=1 and rdata[p]=mem[addr_p sampled at N] in cycle N+1.
  - rvalid[p] is 0 in cycles with no grant to p. rdata[p] holds its last value.
- Maximum throughput is one word per port per cycle when there is no bank conflict.
- Reset mid-operation:
  - All outputs return to reset values immediately and in-flight reads are dropped.
  - gnt is forced to 0 while reset=0.
  - The load port is accepting again on the first edge after reset is released.

## Test plan
- Load 0x00←0x80, 0x01←0x02, 0x02←0x98, 0x03←0x9C, with load_last on the 4th beat. Required: load_ready=1 throughout the load, run=1 and load_ready=0 on the cycle after the 4th beat, and a further load_valid beat to 0x00←0xFF leaves mem[0]=0x80.
- In RUN, port 0 requests address 2. Required: gnt[0]=1 in the same cycle, then rvalid[0]=1 with rdata[0]=0x98 in the next cycle, and rvalid[0]=0 in the cycle after that.
- With NUM_BANKS=4, ports 0/1/2 request addresses 0/4/8 together and hold req. Required: grants go to port 0, then 1, then 2 on consecutive cycles, and each rvalid follows its grant by 1 cycle with the correct word.
- Ports 0–3 request addresses 0–3 in the same cycle. Required: all four gnt=1 in that cycle and all four rvalid=1 in the next cycle.
- Ports 0 and 5 continuously request addresses 1 and 5 (bank 1). Required: grants alternate 0,5,0,5 with no starvation, and gnt=0 on every other port.
- Pull reset low while rvalid[3]=1 and the FSM is in RUN. Required: rvalid, gnt and run go to 0 immediately and load_ready goes to 1. A req during LOAD gets no gnt. Reload followed by fetch returns the newly loaded data.
